// File: rtl/sd_pkg.sv
// Shared encodings and constants for the SD CMD-line engine.
package sd_pkg;

  localparam logic [1:0] RESP_NONE  = 2'd0;
  localparam logic [1:0] RESP_SHORT = 2'd1;
  localparam logic [1:0] RESP_LONG  = 2'd2;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_CRC     = 1;
  localparam int ERR_END     = 2;
  localparam int ERR_IDX     = 3;

  localparam int FRAME_SHORT  = 48;
  localparam int FRAME_LONG   = 136;
  localparam int CMD_HDR_BITS = 40;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  typedef enum logic [2:0] {ST_IDLE, ST_TX, ST_WAIT, ST_RX, ST_GAP} state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB first, one bit per enabled cycle; clear wins over enable.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[6];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: sends a 48-bit command, captures a none/short/long response and checks it.
// Every state and counter advances only on sd_clk_en (one SD bit-time per strobe).
module sd_cmd_engine
  import sd_pkg::*;
#(
  parameter int ARG_W   = 32,
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8,
  parameter int RESP_W  = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sd_clk_en,
  input  logic              cmd_start,
  input  logic [5:0]        cmd_index,
  input  logic [ARG_W-1:0]  cmd_arg,
  input  logic [1:0]        resp_type,
  input  logic              crc_chk_en,
  input  logic              idx_chk_en,
  input  logic              cmd_pin_in,
  output logic              cmd_pin_out,
  output logic              cmd_pin_oe,
  output logic              busy,
  output logic              done,
  output logic [3:0]        err,
  output logic [RESP_W-1:0] resp
);

  localparam int TW = $clog2(NCR_MAX + 1);

  if (ARG_W != 32) begin : g_arg_w_check
    $error("sd_cmd_engine: ARG_W must be 32");
  end

  state_t        state, state_nxt;
  logic [7:0]    bit_cnt;
  logic [TW-1:0] tcnt, tcnt_inc;
  logic [126:0]  rx_sr;
  logic [127:0]  rx_full;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic          none_q, long_q, crc_en_q, idx_en_q, done_q;
  logic [39:0]   hdr;
  logic [5:0]    hdr_sel;
  logic [2:0]    crc_sel;
  logic          accept, tx_bit, tx_last, start_det, wait_to, rx_last, gap_last;
  logic          crc_clr, crc_en, crc_din, crc_bad, end_bad, idx_bad;
  logic [6:0]    crc;

  assign accept   = (state == ST_IDLE) && cmd_start;
  assign hdr      = {2'b01, idx_q, arg_q};
  assign hdr_sel  = 6'(8'(CMD_HDR_BITS - 1) - bit_cnt);
  assign crc_sel  = 3'(8'(FRAME_SHORT - 2) - bit_cnt);
  assign tx_last  = (bit_cnt == 8'(FRAME_SHORT - 1));
  assign tcnt_inc = tcnt + TW'(1);
  // The first two WAIT strobes are the minimum NCR; the line is ignored there.
  assign start_det = (state == ST_WAIT) && sd_clk_en && !cmd_pin_in && (tcnt_inc > TW'(2));
  assign wait_to   = (state == ST_WAIT) && sd_clk_en && !start_det && (tcnt_inc >= TW'(NCR_MAX));
  // Only the last 128 frame bits carry anything reported, so older bits fall off the top.
  assign rx_full  = {rx_sr, cmd_pin_in};
  assign rx_last  = (bit_cnt == (long_q ? 8'(FRAME_LONG - 1) : 8'(FRAME_SHORT - 1)));
  assign gap_last = (bit_cnt == 8'(NCC_MIN - 1));
  assign crc_bad  = crc_en_q && (rx_full[7:1] != crc);
  assign end_bad  = !rx_full[0];
  assign idx_bad  = !long_q && idx_en_q && (rx_full[45:40] != idx_q);

  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < 8'(CMD_HDR_BITS))         tx_bit = hdr[hdr_sel];
    else if (bit_cnt < 8'(FRAME_SHORT - 1)) tx_bit = crc[crc_sel];
  end

  always_comb begin
    crc_en = 1'b0;
    case (state)
      ST_TX:   crc_en = sd_clk_en && (bit_cnt < 8'(CMD_HDR_BITS));
      ST_WAIT: crc_en = start_det && !long_q;
      ST_RX:   crc_en = sd_clk_en && (long_q ? (bit_cnt >= 8'd8 && bit_cnt < 8'(FRAME_LONG - 8))
                                              : (bit_cnt < 8'(CMD_HDR_BITS)));
      default: crc_en = 1'b0;
    endcase
  end

  assign crc_clr = accept || ((state == ST_TX) && sd_clk_en && tx_last);
  assign crc_din = (state == ST_TX) ? tx_bit : cmd_pin_in;

  sd_crc7 u_crc7 (
    .clock  (clock),
    .reset  (reset),
    .clear  (crc_clr),
    .enable (crc_en),
    .bit_in (crc_din),
    .crc    (crc)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_start) state_nxt = ST_TX;
      ST_TX:   if (sd_clk_en && tx_last) state_nxt = none_q ? ST_GAP : ST_WAIT;
      ST_WAIT: if (start_det) state_nxt = ST_RX;
               else if (wait_to) state_nxt = ST_GAP;
      ST_RX:   if (sd_clk_en && rx_last) state_nxt = ST_GAP;
      ST_GAP:  if (sd_clk_en && gap_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_pin_oe  = (state == ST_TX);
    cmd_pin_out = (state == ST_TX) ? tx_bit : 1'b1;
    busy        = (state != ST_IDLE);
    done        = done_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt  <= '0;
      tcnt     <= '0;
      rx_sr    <= '0;
      idx_q    <= '0;
      arg_q    <= '0;
      none_q   <= 1'b0;
      long_q   <= 1'b0;
      crc_en_q <= 1'b0;
      idx_en_q <= 1'b0;
      done_q   <= 1'b0;
      err      <= '0;
      resp     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: if (cmd_start) begin
          idx_q    <= cmd_index;
          arg_q    <= 32'(cmd_arg);
          none_q   <= (resp_type == RESP_NONE);
          long_q   <= (resp_type == RESP_LONG);
          crc_en_q <= crc_chk_en;
          idx_en_q <= idx_chk_en;
          err      <= '0;
          bit_cnt  <= '0;
        end
        ST_TX: if (sd_clk_en) begin
          bit_cnt <= tx_last ? 8'd0 : bit_cnt + 8'd1;
          if (tx_last) tcnt <= '0;
        end
        ST_WAIT: if (sd_clk_en) begin
          if (start_det) begin
            rx_sr   <= rx_full[126:0];
            bit_cnt <= 8'd1;
          end else if (wait_to) begin
            err[ERR_TIMEOUT] <= 1'b1;
            bit_cnt          <= '0;
          end else begin
            tcnt <= tcnt_inc;
          end
        end
        ST_RX: if (sd_clk_en) begin
          rx_sr   <= rx_full[126:0];
          bit_cnt <= rx_last ? 8'd0 : bit_cnt + 8'd1;
          if (rx_last) begin
            if (crc_bad) err[ERR_CRC] <= 1'b1;
            if (end_bad) err[ERR_END] <= 1'b1;
            if (idx_bad) err[ERR_IDX] <= 1'b1;
            resp <= long_q ? RESP_W'(rx_full[127:8]) : RESP_W'(rx_full[39:8]);
          end
        end
        ST_GAP: if (sd_clk_en) begin
          bit_cnt <= bit_cnt + 8'd1;
          if (gap_last) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
